// File: rtl/types_pkg.sv
// Shared NoC payload types.
package types;

    localparam int unsigned DEST_W    = 4;
    localparam int unsigned SRC_W     = 4;
    localparam int unsigned PAYLOAD_W = 24;

    typedef struct packed {
        logic [DEST_W-1:0]    dest;
        logic [SRC_W-1:0]     src;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

endpackage

// File: rtl/flit_out_arbiter_if.sv
// Four flit sources plus the shared registered flit output of the transmit path.
interface flit_out_arbiter_if;
    import types::*;

    flit_t      ack_flit;
    logic       ack_flit_valid;
    logic       ack_flit_ready;
    flit_t      waiting_ack_buffer_flit;
    logic       waiting_ack_buffer_valid;
    logic       waiting_ack_buffer_ready;
    flit_t      forwarding_flit;
    logic       forwarding_flit_valid;
    logic       forwarding_flit_ready;
    flit_t      cpu_to_noc_flit;
    logic       cpu_to_noc_flit_valid;
    logic       cpu_to_noc_flit_ready;
    flit_t      flit_out;
    logic       flit_out_valid;
    logic       flit_out_ready;
    logic [1:0] grant_src;

    // Arbiter side
    modport slave (
        input  ack_flit, ack_flit_valid,
        input  waiting_ack_buffer_flit, waiting_ack_buffer_valid,
        input  forwarding_flit, forwarding_flit_valid,
        input  cpu_to_noc_flit, cpu_to_noc_flit_valid,
        input  flit_out_ready,
        output ack_flit_ready, waiting_ack_buffer_ready,
        output forwarding_flit_ready, cpu_to_noc_flit_ready,
        output flit_out, flit_out_valid, grant_src
    );

    // Source / downstream side
    modport master (
        output ack_flit, ack_flit_valid,
        output waiting_ack_buffer_flit, waiting_ack_buffer_valid,
        output forwarding_flit, forwarding_flit_valid,
        output cpu_to_noc_flit, cpu_to_noc_flit_valid,
        output flit_out_ready,
        input  ack_flit_ready, waiting_ack_buffer_ready,
        input  forwarding_flit_ready, cpu_to_noc_flit_ready,
        input  flit_out, flit_out_valid, grant_src
    );

endinterface

// File: rtl/flit_out_arbiter.sv
// Output scheduler: capped strict-priority ack, weighted round-robin over
// retx/fwd/cpu, winner held in a one-entry output register.
module flit_out_arbiter #(
    parameter int unsigned ACK_BURST_MAX = 4,
    parameter int unsigned W_RETX        = 1,
    parameter int unsigned W_FWD         = 2,
    parameter int unsigned W_CPU         = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    flit_out_arbiter_if.slave   bus
);
    import types::*;

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0]        ACK_CAP = CW'(ACK_BURST_MAX);
    localparam logic [3:1][CW-1:0]   WEIGHT  = {CW'(W_CPU), CW'(W_FWD), CW'(W_RETX)};

    if (ACK_BURST_MAX < 1 || ACK_BURST_MAX > 15) begin : g_bad_ack_burst
        $error("ACK_BURST_MAX must be in 1..15");
    end
    if (W_RETX < 1 || W_RETX > 15) begin : g_bad_w_retx
        $error("W_RETX must be in 1..15");
    end
    if (W_FWD < 1 || W_FWD > 15) begin : g_bad_w_fwd
        $error("W_FWD must be in 1..15");
    end
    if (W_CPU < 1 || W_CPU > 15) begin : g_bad_w_cpu
        $error("W_CPU must be in 1..15");
    end

    logic [3:1][CW-1:0] credit_q, credit_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]      ack_run_q, ack_run_d;
    flit_t              flit_out_q, flit_out_d;
    logic               flit_out_valid_q, flit_out_valid_d;
    logic [1:0]         grant_src_q, grant_src_d;

    logic               load, other_valid, reload, ack_win, found;
    logic               grant_ack, grant_wrr;
    logic [3:1]         vld, elig;
    logic [3:1][CW-1:0] eff;
    logic [1:0]         sel, cand;
    logic [3:0]         ready_c;

    function automatic logic [1:0] next_cls(input logic [1:0] c);
        return (c == 2'd3) ? 2'd1 : c + 2'd1;
    endfunction

    // Selection, handshake and next-state
    always_comb begin
        credit_d         = credit_q;
        rr_ptr_d         = rr_ptr_q;
        ack_run_d        = ack_run_q;
        flit_out_d       = flit_out_q;
        flit_out_valid_d = flit_out_valid_q;
        grant_src_d      = grant_src_q;
        ready_c          = '0;
        sel              = rr_ptr_q;
        cand             = rr_ptr_q;
        found            = 1'b0;

        vld         = {bus.cpu_to_noc_flit_valid, bus.forwarding_flit_valid,
                       bus.waiting_ack_buffer_valid};
        other_valid = |vld;

        // Reload when something is valid but every valid class is out of credit
        reload = other_valid;
        for (int i = 1; i <= 3; i++) begin
            if (vld[i] && credit_q[i] != '0) reload = 1'b0;
        end
        for (int i = 1; i <= 3; i++) begin
            eff[i]  = reload ? WEIGHT[i] : credit_q[i];
            elig[i] = vld[i] && (eff[i] != '0);
        end

        for (int k = 0; k < 3; k++) begin
            if (!found && elig[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
            cand = next_cls(cand);
        end

        load      = !flit_out_valid_q || bus.flit_out_ready;
        ack_win   = bus.ack_flit_valid && (!other_valid || ack_run_q < ACK_CAP);
        grant_ack = rst_n && load && ack_win;
        grant_wrr = rst_n && load && !ack_win && found;

        if (grant_ack) begin
            ready_c[0]       = 1'b1;
            flit_out_d       = bus.ack_flit;
            flit_out_valid_d = 1'b1;
            grant_src_d      = 2'd0;
            if (!other_valid)
                ack_run_d = '0;
            else if (ack_run_q != ACK_CAP)
                ack_run_d = ack_run_q + CW'(1);
        end else if (grant_wrr) begin
            ready_c[sel]     = 1'b1;
            flit_out_valid_d = 1'b1;
            grant_src_d      = sel;
            ack_run_d        = '0;
            case (sel)
                2'd1:    flit_out_d = bus.waiting_ack_buffer_flit;
                2'd2:    flit_out_d = bus.forwarding_flit;
                default: flit_out_d = bus.cpu_to_noc_flit;
            endcase
            for (int i = 1; i <= 3; i++) begin
                credit_d[i] = reload ? WEIGHT[i] : credit_q[i];
            end
            credit_d[sel] = eff[sel] - CW'(1);
            rr_ptr_d      = (credit_d[sel] == '0) ? next_cls(sel) : sel;
        end else if (load) begin
            flit_out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q         <= WEIGHT;
            rr_ptr_q         <= 2'd1;
            ack_run_q        <= '0;
            flit_out_q       <= '0;
            flit_out_valid_q <= 1'b0;
            grant_src_q      <= 2'd0;
        end else begin
            credit_q         <= credit_d;
            rr_ptr_q         <= rr_ptr_d;
            ack_run_q        <= ack_run_d;
            flit_out_q       <= flit_out_d;
            flit_out_valid_q <= flit_out_valid_d;
            grant_src_q      <= grant_src_d;
        end
    end

    assign bus.ack_flit_ready           = ready_c[0];
    assign bus.waiting_ack_buffer_ready = ready_c[1];
    assign bus.forwarding_flit_ready    = ready_c[2];
    assign bus.cpu_to_noc_flit_ready    = ready_c[3];
    assign bus.flit_out                 = flit_out_q;
    assign bus.flit_out_valid           = flit_out_valid_q;
    assign bus.grant_src                = grant_src_q;

endmodule

// File: tb/tb_flit_out_arbiter.sv
// Directed bench for flit_out_arbiter with default parameters (cap 4, weights 1/2/1).
module tb_flit_out_arbiter;
    import types::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    flit_out_arbiter_if bus();

    flit_out_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cnt [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic flit_t mk(input int s);
        flit_t f;
        f.dest    = 4'hF;
        f.src     = 4'(s);
        f.payload = 24'(32'h1000 * (s + 1) + s);
        return f;
    endfunction

    function automatic logic [31:0] readys();
        return 32'({bus.cpu_to_noc_flit_ready, bus.forwarding_flit_ready,
                    bus.waiting_ack_buffer_ready, bus.ack_flit_ready});
    endfunction

    // v bit0 ack, bit1 retx, bit2 fwd, bit3 cpu
    task automatic set_v(input logic [3:0] v);
        bus.ack_flit_valid           = v[0];
        bus.waiting_ack_buffer_valid = v[1];
        bus.forwarding_flit_valid    = v[2];
        bus.cpu_to_noc_flit_valid    = v[3];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One loading cycle: expected source ready now, then registered output after the edge
    task automatic cycle_expect(input string tag, input int exp);
        #1;
        check({tag, "_ready"}, readys(), 32'(1) << exp);
        tick();
        check({tag, "_src"},   32'(bus.grant_src), 32'(exp));
        check({tag, "_flit"},  32'(bus.flit_out), 32'(mk(exp)));
        check({tag, "_valid"}, 32'(bus.flit_out_valid), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_v(4'hF);
        bus.flit_out_ready = 1'b1;
        #1;
        check("rst_readys", readys(), 32'd0);
        check("rst_valid", 32'(bus.flit_out_valid), 32'd0);
        check("rst_src", 32'(bus.grant_src), 32'd0);
        check("rst_flit", 32'(bus.flit_out), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_v(4'h0);
    endtask

    initial begin
        bus.ack_flit                = mk(0);
        bus.waiting_ack_buffer_flit = mk(1);
        bus.forwarding_flit         = mk(2);
        bus.cpu_to_noc_flit         = mk(3);
        bus.flit_out_ready          = 1'b1;
        set_v(4'h0);

        // Single cpu flit, output drains the next cycle, flit held
        do_reset();
        set_v(4'b1000);
        cycle_expect("single", 3);
        set_v(4'b0000);
        #1;
        check("single_idle_ready", readys(), 32'd0);
        tick();
        check("single_drain_valid", 32'(bus.flit_out_valid), 32'd0);
        check("single_hold_flit", 32'(bus.flit_out), 32'(mk(3)));

        // Ack cap against continuous fwd
        do_reset();
        set_v(4'b0101);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) cycle_expect("cap_ack", 0);
            cycle_expect("cap_fwd", 2);
        end

        // WRR 1/2/1 pattern then exact shares over 400 flits
        do_reset();
        set_v(4'b1110);
        for (int r = 0; r < 2; r++) begin
            cycle_expect("wrr_a", 1);
            cycle_expect("wrr_b", 2);
            cycle_expect("wrr_c", 2);
            cycle_expect("wrr_d", 3);
        end
        for (int s = 0; s < 4; s++) cnt[s] = 0;
        for (int k = 0; k < 400; k++) begin
            tick();
            cnt[bus.grant_src]++;
        end
        check("share_ack", 32'(cnt[0]), 32'd0);
        check("share_retx", 32'(cnt[1]), 32'd100);
        check("share_fwd", 32'(cnt[2]), 32'd200);
        check("share_cpu", 32'(cnt[3]), 32'd100);
        check("share_valid", 32'(bus.flit_out_valid), 32'd1);

        // Stall holds the output, then WRR resumes mid-burst
        do_reset();
        set_v(4'b1110);
        cycle_expect("stall_pre0", 1);
        cycle_expect("stall_pre1", 2);
        bus.flit_out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("stall_readys", readys(), 32'd0);
            tick();
            check("stall_src", 32'(bus.grant_src), 32'd2);
            check("stall_flit", 32'(bus.flit_out), 32'(mk(2)));
            check("stall_valid", 32'(bus.flit_out_valid), 32'd1);
        end
        bus.flit_out_ready = 1'b1;
        cycle_expect("resume0", 2);
        cycle_expect("resume1", 3);
        cycle_expect("resume2", 1);
        cycle_expect("resume3", 2);
        cycle_expect("resume4", 2);
        cycle_expect("resume5", 3);

        // Lone ack never accumulates run length
        do_reset();
        set_v(4'b0001);
        for (int k = 0; k < 10; k++) cycle_expect("lone_ack", 0);
        set_v(4'b0101);
        for (int k = 0; k < 4; k++) cycle_expect("late_ack", 0);
        cycle_expect("late_fwd", 2);
        cycle_expect("late_ack2", 0);

        // Asynchronous reset mid-burst restarts WRR from class 1 with full credit
        do_reset();
        set_v(4'b1110);
        cycle_expect("mid_pre0", 1);
        cycle_expect("mid_pre1", 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.flit_out_valid), 32'd0);
        check("mid_rst_flit", 32'(bus.flit_out), 32'd0);
        check("mid_rst_readys", readys(), 32'd0);
        @(negedge clk);
        #1;
        check("mid_rst_readys2", readys(), 32'd0);
        rst_n = 1'b1;
        cycle_expect("post_rst0", 1);
        cycle_expect("post_rst1", 2);
        cycle_expect("post_rst2", 2);
        cycle_expect("post_rst3", 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/flit_out_arbiter.md
Name: flit_out_arbiter

Overview:
- Registered, fair output scheduler for the NoC transmit path.
- Shares one flit output between four sources: ack, waiting-ack (retransmit), forwarding and cpu_to_noc.
- Ack has strict priority, with a burst cap so the other sources are not starved.
- The other three sources share the output by weighted round-robin, and the winner is held in a one-entry output register.

Parameters:
ACK_BURST_MAX, 4, max consecutive ack grants while any other source is valid (1..15)
W_RETX, 1, WRR weight of waiting-ack source (1..15)
W_FWD, 2, WRR weight of forwarding source (1..15)
W_CPU, 1, WRR weight of cpu_to_noc source (1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ack_flit  in  types::flit_t  ack flit
ack_flit_valid  in  1  ack flit valid
ack_flit_ready  out  1  ack flit consumed this cycle
waiting_ack_buffer_flit  in  types::flit_t  retransmit flit
waiting_ack_buffer_valid  in  1  retransmit flit valid
waiting_ack_buffer_ready  out  1  retransmit flit consumed this cycle
forwarding_flit  in  types::flit_t  forwarded flit
forwarding_flit_valid  in  1  forwarded flit valid
forwarding_flit_ready  out  1  forwarded flit consumed this cycle
cpu_to_noc_flit  in  types::flit_t  local injected flit
cpu_to_noc_flit_valid  in  1  local flit valid
cpu_to_noc_flit_ready  out  1  local flit consumed this cycle
flit_out  out  types::flit_t  registered output flit
flit_out_valid  out  1  output register holds a flit
flit_out_ready  in  1  downstream accepts flit_out
grant_src  out  2  source of the flit in the output register: 0 ack, 1 retx, 2 fwd, 3 cpu

Behaviour:
Reset and clocking:
- One clock; reset is asynchronous and active-low.
- Reset values: flit_out = 0, flit_out_valid = 0, grant_src = 0.
- All input readys are 0 while rst_n = 0.
- Internal state reset: credits = weights, rr_ptr = 1, ack_run = 0.

Output register and handshake:
- load = !flit_out_valid | flit_out_ready.
- At most one input ready is high per cycle.
- An input ready is high only if that input is valid, load = 1 and that input is selected.
- A selected input is consumed in the same cycle its ready is high.
- On load with a selection: the register takes the selected flit, flit_out_valid <= 1 and grant_src <= the selected index. Latency is 1 cycle from input to flit_out.
- On load with no valid input: flit_out_valid <= 0 and flit_out is held.
- While flit_out_valid = 1 and flit_out_ready = 0: flit_out and grant_src stay stable and all readys are 0.
- Full throughput: one flit per cycle while downstream keeps flit_out_ready = 1.

Ack selection:
- other_valid = OR of the retx, fwd and cpu valids.
- Ack wins if ack_flit_valid & (!other_valid | ack_run < ACK_BURST_MAX).
- On an ack grant with other_valid = 1: ack_run increments, saturating at ACK_BURST_MAX.
- On an ack grant with other_valid = 0: ack_run <= 0.
- On any non-ack grant: ack_run <= 0.
- ack_run does not change in cycles with no grant.
- Ack grants never change WRR state.

WRR among classes 1..3 (used when ack does not win):
- credit[i] is 4 bits wide.
- eligible[i] = valid[i] & credit[i] != 0.
- If no class is eligible but some class is valid, the arbiter reloads: it uses credit = weight for all classes this cycle.
- Pick the first eligible class, searching from rr_ptr in the order 1→2→3→1.
- On a grant to class i:
  - credit[i] <= effective credit - 1. On a reload cycle, every non-granted class is written to its weight.
  - If the new credit[i] = 0: rr_ptr <= next(i). Otherwise rr_ptr <= i, so class i continues its burst.
- On a non-reload grant, credits of non-granted classes are unchanged.
- No WRR state changes on cycles without a WRR grant, including stalls.

Boundaries:
- Reset mid-operation: the held output flit is dropped (valid 0), all state returns to reset values, and no ready pulses during reset.
- A valid input that drops while not selected has no effect.
- An input valid that rises in the same cycle as load is eligible that cycle; there is no extra delay.
- Weight parameters outside 1..15 are a compile-time error; the check is an elaboration assertion.

Test Plan:
- Single cpu flit, flit_out_ready = 1 → cpu_to_noc_flit_ready = 1 in cycle 0; flit_out_valid = 1 and grant_src = 3 in cycle 1; valid = 0 in cycle 2.
- Ack and fwd valid continuously, ACK_BURST_MAX = 4 → grant sequence 0,0,0,0,2,0,0,0,0,2,…
- Retx, fwd and cpu saturated, weights 1/2/1, no ack → grant_src repeats 1,2,2,3; exactly 25/50/25% over 400 flits.
- Output stalled: flit_out_ready = 0 for 5 cycles with all inputs valid → flit_out stable, all readys 0; after release, sequence resumes without skipping or repeating a source.
- Only ack valid for 10 cycles, then fwd rises → fwd is not blocked by the cap and ack_run restarts from 0: grants 0,0,0,0 then 2.
- Assert rst_n = 0 while flit_out_valid = 1 and a WRR burst is mid-way → flit_out_valid = 0 immediately; after release the first WRR grant starts from class 1 with full credits.
